frame_buffer_ctrl: RTL

- Ping-pong frame store plus select generator; sits directly upstream of the frame output multiplexer.
- Accepts pixels from the pixel source over a valid/ready handshake and fills two frame buffers alternately.
- On each display frame boundary, hands a completed buffer to the display side.
- Drives both buffer read-data buses and the one-hot select triple (sel_buf0, sel_blank, sel_buf1) that the multiplexer consumes.

---
 rtl/frame_buf_pkg.sv | 15 +
 rtl/frame_buf_ram.sv | 33 +++
 rtl/frame_buffer_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/frame_buf_pkg.sv
// Shared types and defaults for the ping-pong frame store.
// Each frame buffer walks EMPTY -> FILL -> READY -> SHOW -> EMPTY.
package frame_buf_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_FILL  = 2'd1,
        BUF_READY = 2'd2,
        BUF_SHOW  = 2'd3
    } bufState_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 64;

endpackage

// File: rtl/frame_buf_ram.sv
// One frame buffer: single write port, registered single read port.
// The read register clears on reset so the data bus starts at zero.
module frame_buf_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdData <= '0;
        end else begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Ping-pong frame store feeding the frame output multiplexer.
// Define REPEAT_LAST_FRAME_EN to hold the last shown frame on underrun instead of blanking.
module frame_buffer_ctrl
    import frame_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              frame_start,
    input  logic              rd_en,
    output logic [DATA_W-1:0] buf0_data,
    output logic [DATA_W-1:0] buf1_data,
    output logic              sel_buf0,
    output logic              sel_blank,
    output logic              sel_buf1,
    output logic              underrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bufState_t         bufState    [2];
    bufState_t         bufStateNxt [2];
    logic              wrSel;
    logic              nxtSel;
    logic [ADDR_W-1:0] wrAddr;
    logic [ADDR_W-1:0] rdAddr;
    logic [ADDR_W-1:0] rdAddrNxt;
    logic [2:0]        selQ;
    logic [2:0]        selNxt;
    logic              wrAccept;
    logic              wrLast;
    logic              showNext;
    logic              freeShown;

    // A pixel moves only in a cycle where wr_valid and wr_ready are both high;
    // wr_ready depends on registered state only, never on wr_valid.
    assign wr_ready = (bufState[wrSel] == BUF_EMPTY) || (bufState[wrSel] == BUF_FILL);
    assign wrAccept = wr_valid && wr_ready;
    assign wrLast   = wrAccept && (wrAddr == LAST_ADDR);

    // Uses registered state, so a buffer finishing in this very cycle waits a frame.
    assign showNext = frame_start && (bufState[nxtSel] == BUF_READY);

`ifdef REPEAT_LAST_FRAME_EN
    assign freeShown = showNext;
`else
    assign freeShown = frame_start;
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bufStateNxt[i] = bufState[i];
            if (freeShown && bufState[i] == BUF_SHOW) begin
                bufStateNxt[i] = BUF_EMPTY;
            end
            if (showNext && nxtSel == 1'(i)) begin
                bufStateNxt[i] = BUF_SHOW;
            end
            if (wrAccept && wrSel == 1'(i)) begin
                bufStateNxt[i] = wrLast ? BUF_READY : BUF_FILL;
            end
        end
    end

    // Select order is {buf0, blank, buf1}; exactly one bit is ever set.
    always_comb begin
        selNxt = selQ;
        if (showNext) begin
            selNxt = nxtSel ? 3'b001 : 3'b100;
        end else if (freeShown) begin
            selNxt = 3'b010;
        end
    end

    always_comb begin
        rdAddrNxt = rdAddr;
        if (frame_start) begin
            rdAddrNxt = '0;
        end else if (rd_en && rdAddr != LAST_ADDR) begin
            rdAddrNxt = rdAddr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bufState <= '{BUF_EMPTY, BUF_EMPTY};
            wrSel    <= 1'b0;
            nxtSel   <= 1'b0;
            wrAddr   <= '0;
            rdAddr   <= '0;
            selQ     <= 3'b010;
            underrun <= 1'b0;
        end else begin
            bufState <= bufStateNxt;
            if (wrAccept) begin
                wrAddr <= wrLast ? '0 : wrAddr + 1'b1;
            end
            if (wrLast) begin
                wrSel <= ~wrSel;
            end
            if (showNext) begin
                nxtSel <= ~nxtSel;
            end
            rdAddr   <= rdAddrNxt;
            selQ     <= selNxt;
            underrun <= frame_start && !showNext;
        end
    end

    assign sel_buf0  = selQ[2];
    assign sel_blank = selQ[1];
    assign sel_buf1  = selQ[0];

    // RAMs are addressed with the next read address so the data bus tracks rdAddr.
    frame_buf_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) ram0 (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (wrAccept && !wrSel),
        .wrAddr (wrAddr),
        .wrData (wr_data),
        .rdAddr (rdAddrNxt),
        .rdData (buf0_data)
    );

    frame_buf_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) ram1 (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (wrAccept && wrSel),
        .wrAddr (wrAddr),
        .wrData (wr_data),
        .rdAddr (rdAddrNxt),
        .rdData (buf1_data)
    );

endmodule
